// File: rtl/mole_game_ctrl_pkg.sv
// Shared state codes, BCD constants and BCD arithmetic helpers for the mole game blocks.
package mole_game_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_OVER = 2'd2;

  localparam int          BCD_W         = 4;
  localparam logic [11:0] SCORE_MAX_BCD = 12'h999;

  function automatic logic [2*BCD_W-1:0] bcd_from_int(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Saturates at 999 rather than wrapping to 000.
  function automatic logic [3*BCD_W-1:0] bcd_inc3(input logic [3*BCD_W-1:0] v);
    logic [3*BCD_W-1:0] r;
    r = v;
    if (v != SCORE_MAX_BCD) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [2*BCD_W-1:0] bcd_dec2(input logic [2*BCD_W-1:0] v);
    logic [2*BCD_W-1:0] r;
    r = v;
    if (v[3:0] != 4'd0) begin
      r[3:0] = v[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      r[7:4] = v[7:4] - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mole_game_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, shared by the game blocks.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400) : {1'b0, lfsr_q[15:1]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round controller driven by a divided-clock game tick.
// Optional pause input is built in when GAME_PAUSE_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for first start, mole dark, time shows full round
//   RUN     | round in progress, ticks count down, hits score
//   OVER    | round finished, score and 00 time held until start
module mole_game_ctrl
  import mole_game_ctrl_pkg::*;
#(
  parameter int          GAME_SECONDS = 30,
  parameter int          NUM_MOLES    = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_in_i,
  input  logic                 start_i,
  input  logic [NUM_MOLES-1:0] hit_i,
`ifdef GAME_PAUSE_EN
  input  logic                 pause_i,
`endif
  output logic [NUM_MOLES-1:0] mole_o,
  output logic [7:0]           time_bcd_o,
  output logic [11:0]          score_bcd_o,
  output logic                 running_o,
  output logic                 game_over_o
);

  localparam int         IDX_W     = $clog2(NUM_MOLES);
  localparam logic [7:0] TIME_INIT = bcd_from_int(GAME_SECONDS);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d;
  logic [7:0]           time_q, time_d;
  logic [11:0]          score_q, score_d;
  logic                 tick_q, start_q;
  logic [NUM_MOLES-1:0] hit_q;

  logic                 tick_p, start_p, run_en;
  logic [NUM_MOLES-1:0] hit_p, mole_new;
  logic [IDX_W-1:0]     cand, idx_new;
  logic [15:0]          lfsr_q;
  logic [7:0]           lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .q_o     (lfsr_q)
  );

  // Upper LFSR bits are left for other game blocks.
  assign lfsr_unused = lfsr_q[15:8];

  assign tick_p  = tick_in_i & ~tick_q;
  assign start_p = start_i & ~start_q;
  assign hit_p   = hit_i & ~hit_q;

`ifdef GAME_PAUSE_EN
  assign run_en = ~pause_i;
`else
  assign run_en = 1'b1;
`endif

  assign cand     = IDX_W'(lfsr_q[7:0] % 8'(NUM_MOLES));
  assign idx_new  = (cand != idx_q) ? cand :
                    (cand == IDX_W'(NUM_MOLES - 1)) ? '0 : cand + IDX_W'(1);
  assign mole_new = NUM_MOLES'(1) << idx_new;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mole_d  = mole_q;
    time_d  = time_q;
    score_d = score_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        mole_d = '0;
        if (state_q == ST_IDLE) time_d = TIME_INIT;
        if (start_p) begin
          state_d = ST_RUN;
          score_d = '0;
          time_d  = TIME_INIT;
          idx_d   = idx_new;
          mole_d  = mole_new;
        end
      end
      ST_RUN: begin
        if (run_en) begin
          if ((hit_p & mole_q) != '0) begin
            score_d = bcd_inc3(score_q);
            mole_d  = '0;
          end
          // A tick overrides the hit's mole clear; the final tick darkens it.
          if (tick_p) begin
            if (time_q == 8'h01) begin
              state_d = ST_OVER;
              time_d  = 8'h00;
              mole_d  = '0;
            end else begin
              time_d = bcd_dec2(time_q);
              idx_d  = idx_new;
              mole_d = mole_new;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mole_q  <= '0;
      time_q  <= TIME_INIT;
      score_q <= '0;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mole_q  <= mole_d;
      time_q  <= time_d;
      score_q <= score_d;
      tick_q  <= tick_in_i;
      start_q <= start_i;
      hit_q   <= hit_i;
    end
  end

  assign mole_o      = mole_q;
  assign time_bcd_o  = time_q;
  assign score_bcd_o = score_q;
  assign running_o   = (state_q == ST_RUN);
  assign game_over_o = (state_q == ST_OVER);

endmodule
